ctrl_prefetch: RTL and testbench

- Instruction-side memory request scheduler between the instruction cache's RAM port and the memory controller's instruction-fetch port.
- Serves demand word fetches from the instruction cache.
- Uses idle memory-port cycles to fetch the next sequential instruction words into a small FIFO prefetch buffer.
- Flushes and cancels all prefetch work on branch misprediction (discard).

---
 rtl/ctrl_prefetch_if.sv | 17 +
 rtl/ctrl_prefetch.sv | 132 +++++++++++++
 tb/tb_ctrl_prefetch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_prefetch_if.sv
// ctrl_prefetch_if: instruction-cache demand port and memory-controller fetch port of the prefetch scheduler
interface ctrl_prefetch_if;
  logic        discard;
  logic        read;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] data;
  logic        ram_read;
  logic [31:0] ram_addr;
  logic        ram_busy;
  logic        ram_ready;
  logic [31:0] ram_data;
  modport master (output discard, read, addr, ram_busy, ram_ready, ram_data,
                  input ready, data, ram_read, ram_addr);
  modport slave (input discard, read, addr, ram_busy, ram_ready, ram_data,
                 output ready, data, ram_read, ram_addr);
endinterface

// File: rtl/ctrl_prefetch.sv
// ctrl_prefetch: demand fetch scheduler with sequential prefetch into a small FIFO
module ctrl_prefetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PF_LIMIT = 32'h00020000
) (
  input logic           clock,
  input logic           reset,
  ctrl_prefetch_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d, widx;
  logic [31:0]     pf_addr_q, pf_addr_d;
  logic            pf_valid_q, pf_valid_d;
  logic            acc_q, acc_d;
  logic [31:0]     fifo_addr_q [DEPTH];
  logic [31:0]     fifo_addr_d [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  logic [31:0]     fifo_data_d [DEPTH];
  logic            kill, hit, miss, pf_ok, pop, push, clr, rdy, rr;
  logic [31:0]     dat, ra;
  always_comb begin
    kill       = bus.discard | reset;
    hit        = bus.read && count_q != '0 && bus.addr == fifo_addr_q[0];
    miss       = bus.read && !hit && bus.addr != pf_addr_q;
    pf_ok      = pf_valid_q && count_q < CW'(DEPTH) && pf_addr_q < PF_LIMIT;
    state_d    = state_q;
    pf_addr_d  = pf_addr_q;
    pf_valid_d = pf_valid_q;
    pop        = hit;
    push       = 1'b0;
    clr        = 1'b0;
    rdy        = hit;
    dat        = hit ? fifo_data_q[0] : 32'h0;
    rr         = 1'b0;
    ra         = 32'h0;
    case (state_q)
      IDLE: begin
        if (bus.read && !hit) begin
          clr     = 1'b1;
          rr      = 1'b1;
          ra      = bus.addr;
          state_d = DEMAND;
        end else if (pf_ok) begin
          rr      = 1'b1;
          ra      = pf_addr_q;
          state_d = PREFETCH;
        end
      end
      DEMAND: begin
        rr = 1'b1;
        ra = bus.addr;
        if (bus.ram_ready) begin
          rdy        = bus.read;
          dat        = bus.read ? bus.ram_data : 32'h0;
          pf_addr_d  = bus.addr + 32'd4;
          pf_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      PREFETCH: begin
        rr = 1'b1;
        ra = pf_addr_q;
        // an unaccepted prefetch can be retargeted; an accepted one must drain first
        if (miss && bus.ram_busy && !acc_q) begin
          clr     = 1'b1;
          ra      = bus.addr;
          state_d = DEMAND;
        end else if (bus.ram_ready) begin
          state_d   = miss ? DEMAND : IDLE;
          clr       = miss;
          pf_addr_d = miss ? pf_addr_q : pf_addr_q + 32'd4;
          if (!miss && bus.read && !hit) begin
            rdy = 1'b1;
            dat = bus.ram_data;
          end else begin
            push = !miss;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      rdy        = 1'b0;
      dat        = 32'h0;
      rr         = 1'b0;
      ra         = 32'h0;
      push       = 1'b0;
      pop        = 1'b0;
      clr        = 1'b1;
      pf_valid_d = 1'b0;
      state_d    = IDLE;
    end
    acc_d       = state_d == PREFETCH && ((state_q == PREFETCH && acc_q) || (rr && !bus.ram_busy));
    widx        = count_q - CW'(pop);
    count_d     = clr ? '0 : count_q - CW'(pop) + CW'(push);
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      fifo_addr_d[i] = pop ? fifo_addr_q[i+1] : fifo_addr_q[i];
      fifo_data_d[i] = pop ? fifo_data_q[i+1] : fifo_data_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      fifo_addr_d[i] = (push && i == int'(widx)) ? pf_addr_q : fifo_addr_d[i];
      fifo_data_d[i] = (push && i == int'(widx)) ? bus.ram_data : fifo_data_d[i];
    end
  end
  assign bus.ready    = rdy;
  assign bus.data     = dat;
  assign bus.ram_read = rr;
  assign bus.ram_addr = ra;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pf_addr_q   <= 32'h0;
      pf_valid_q  <= 1'b0;
      acc_q       <= 1'b0;
      fifo_addr_q <= '{default: '0};
      fifo_data_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pf_addr_q   <= pf_addr_d;
      pf_valid_q  <= pf_valid_d;
      acc_q       <= acc_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end
endmodule

// File: tb/tb_ctrl_prefetch.sv
// tb_ctrl_prefetch: directed scenarios for the prefetch scheduler with hand-computed expectations
module tb_ctrl_prefetch;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  ctrl_prefetch_if bus();
  ctrl_prefetch #(.DEPTH(2), .PF_LIMIT(32'h00020000)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  // inputs change 1 after the edge, outputs are sampled 1 later, well before the next edge
  task automatic drv(input logic rs, input logic dis, input logic rd, input logic [31:0] a,
                     input logic bsy, input logic rrdy, input logic [31:0] rdat);
    @(posedge clock);
    #1;
    reset         = rs;
    bus.discard   = dis;
    bus.read      = rd;
    bus.addr      = a;
    bus.ram_busy  = bsy;
    bus.ram_ready = rrdy;
    bus.ram_data  = rdat;
    #1;
  endtask
  task automatic test_reset;
    drv(1, 0, 1, 32'h100, 0, 1, 32'h1234);
    n_chk++;
    if (bus.ready !== 1'b0 || bus.data !== 32'h0 || bus.ram_read !== 1'b0 || bus.ram_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b data=%h rr=%b ra=%h want 0 0 0 0", bus.ready, bus.data, bus.ram_read, bus.ram_addr);
    end
    drv(1, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask
  task automatic test_cold_miss;
    drv(0, 0, 1, 32'h100, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h100 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_req got rr=%b ra=%h rdy=%b want 1 100 0", bus.ram_read, bus.ram_addr, bus.ready);
    end
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 1, 32'h100, 0, 0, 32'h0);
      n_chk++;
      if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h100 || bus.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL cold_hold got rr=%b ra=%h rdy=%b want 1 100 0", bus.ram_read, bus.ram_addr, bus.ready);
      end
    end
    drv(0, 0, 1, 32'h100, 0, 1, 32'hDEADBEEF);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL cold_resp got rdy=%b data=%h want 1 deadbeef", bus.ready, bus.data);
    end
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h104) begin
      n_fail++;
      $display("FAIL pf_104 got rr=%b ra=%h want 1 104", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 0, 32'h0, 0, 1, 32'h11110104);
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h108) begin
      n_fail++;
      $display("FAIL pf_108 got rr=%b ra=%h want 1 108", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 0, 32'h0, 0, 1, 32'h22220108);
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
      n_chk++;
      if (bus.ram_read !== 1'b0) begin
        n_fail++;
        $display("FAIL full_stop got rr=%b ra=%h want 0", bus.ram_read, bus.ram_addr);
      end
    end
  endtask
  task automatic test_seq_hits;
    drv(0, 0, 1, 32'h104, 0, 0, 32'h0);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'h11110104 || bus.ram_read !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_104 got rdy=%b data=%h rr=%b want 1 11110104 0", bus.ready, bus.data, bus.ram_read);
    end
    drv(0, 0, 1, 32'h108, 0, 0, 32'h0);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'h22220108 || bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h10C) begin
      n_fail++;
      $display("FAIL hit_108 got rdy=%b data=%h rr=%b ra=%h want 1 22220108 1 10c", bus.ready, bus.data, bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 0, 32'h0, 0, 1, 32'h3333010C);
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    drv(0, 0, 0, 32'h0, 0, 1, 32'h33330110);
  endtask
  task automatic test_mismatch;
    drv(0, 0, 1, 32'h400, 0, 0, 32'h0);
    n_chk++;
    if (bus.ready !== 1'b0 || bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h400) begin
      n_fail++;
      $display("FAIL miss_400 got rdy=%b rr=%b ra=%h want 0 1 400", bus.ready, bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'h400, 0, 1, 32'h44440400);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'h44440400) begin
      n_fail++;
      $display("FAIL resp_400 got rdy=%b data=%h want 1 44440400", bus.ready, bus.data);
    end
  endtask
  task automatic test_retarget;
    drv(0, 0, 0, 32'h0, 1, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h404) begin
      n_fail++;
      $display("FAIL pf_404 got rr=%b ra=%h want 1 404", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'h800, 1, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h800 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL retarget got rr=%b ra=%h rdy=%b want 1 800 0", bus.ram_read, bus.ram_addr, bus.ready);
    end
    drv(0, 0, 1, 32'h800, 0, 1, 32'h88880800);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'h88880800) begin
      n_fail++;
      $display("FAIL resp_800 got rdy=%b data=%h want 1 88880800", bus.ready, bus.data);
    end
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h804) begin
      n_fail++;
      $display("FAIL pf_804 got rr=%b ra=%h want 1 804", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'hC00, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h804 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_hold got rr=%b ra=%h rdy=%b want 1 804 0", bus.ram_read, bus.ram_addr, bus.ready);
    end
    drv(0, 0, 1, 32'hC00, 0, 1, 32'h55550804);
    n_chk++;
    if (bus.ready !== 1'b0 || bus.ram_addr !== 32'h804) begin
      n_fail++;
      $display("FAIL inflight_drop got rdy=%b ra=%h want 0 804", bus.ready, bus.ram_addr);
    end
    drv(0, 0, 1, 32'hC00, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'hC00) begin
      n_fail++;
      $display("FAIL demand_c00 got rr=%b ra=%h want 1 c00", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'hC00, 0, 1, 32'hCCCC0C00);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'hCCCC0C00) begin
      n_fail++;
      $display("FAIL resp_c00 got rdy=%b data=%h want 1 cccc0c00", bus.ready, bus.data);
    end
  endtask
  task automatic test_limit;
    drv(0, 0, 1, 32'h1FFFC, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h1FFFC) begin
      n_fail++;
      $display("FAIL demand_1fffc got rr=%b ra=%h want 1 1fffc", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'h1FFFC, 0, 1, 32'h77771FFC);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
      n_chk++;
      if (bus.ram_read !== 1'b0) begin
        n_fail++;
        $display("FAIL limit_quiet got rr=%b ra=%h want 0", bus.ram_read, bus.ram_addr);
      end
    end
    drv(0, 0, 1, 32'h200, 0, 0, 32'h0);
    drv(0, 0, 1, 32'h200, 0, 1, 32'h66660200);
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h204) begin
      n_fail++;
      $display("FAIL limit_resume got rr=%b ra=%h want 1 204", bus.ram_read, bus.ram_addr);
    end
  endtask
  task automatic test_discard;
    drv(0, 0, 0, 32'h0, 0, 1, 32'h66660204);
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    drv(0, 1, 1, 32'h208, 0, 1, 32'h66660208);
    n_chk++;
    if (bus.ready !== 1'b0 || bus.ram_read !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_kill got rdy=%b rr=%b want 0 0", bus.ready, bus.ram_read);
    end
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_nopf got rr=%b ra=%h want 0", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'h204, 0, 0, 32'h0);
    n_chk++;
    if (bus.ready !== 1'b0 || bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h204) begin
      n_fail++;
      $display("FAIL discard_flushed got rdy=%b rr=%b ra=%h want 0 1 204", bus.ready, bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'h204, 0, 1, 32'h99990204);
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h208) begin
      n_fail++;
      $display("FAIL discard_resume got rr=%b ra=%h want 1 208", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 0, 32'h0, 0, 1, 32'h99990208);
    drv(0, 0, 1, 32'h300, 0, 0, 32'h0);
    drv(1, 0, 1, 32'h300, 0, 1, 32'hAAAA0300);
    n_chk++;
    if (bus.ready !== 1'b0 || bus.data !== 32'h0 || bus.ram_read !== 1'b0 || bus.ram_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid got rdy=%b data=%h rr=%b ra=%h want 0 0 0 0", bus.ready, bus.data, bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nopf got rr=%b ra=%h want 0", bus.ram_read, bus.ram_addr);
    end
  endtask
  task automatic test_back_to_back;
    drv(0, 0, 1, 32'h0, 0, 0, 32'h0);
    drv(0, 0, 1, 32'h0, 0, 1, 32'hD0D0D0D0);
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    drv(0, 0, 0, 32'h0, 0, 1, 32'hD4D4D4D4);
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    n_chk++;
    if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL pf_8 got rr=%b ra=%h want 1 8", bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 1, 32'h4, 0, 1, 32'hD8D8D8D8);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'hD4D4D4D4) begin
      n_fail++;
      $display("FAIL pushpop_hit got rdy=%b data=%h want 1 d4d4d4d4", bus.ready, bus.data);
    end
    drv(0, 0, 1, 32'h8, 0, 0, 32'h0);
    n_chk++;
    if (bus.ready !== 1'b1 || bus.data !== 32'hD8D8D8D8 || bus.ram_read !== 1'b1 || bus.ram_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL pushpop_order got rdy=%b data=%h rr=%b ra=%h want 1 d8d8d8d8 1 c", bus.ready, bus.data, bus.ram_read, bus.ram_addr);
    end
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask
  initial begin
    bus.discard   = 1'b0;
    bus.read      = 1'b0;
    bus.addr      = 32'h0;
    bus.ram_busy  = 1'b0;
    bus.ram_ready = 1'b0;
    bus.ram_data  = 32'h0;
    test_reset;
    test_cold_miss;
    test_seq_hits;
    test_mismatch;
    test_retarget;
    test_limit;
    test_discard;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
